// File: rtl/elementwise_division_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elementwise_division_pkg
//  Brief    : Shared constants and state encoding for the element-wise divider
//  Revision : 1.0 - initial release
// ============================================================================
package elementwise_division_pkg;

  // Default element count; the divisor width equals the element count.
  localparam int N_DEF = 8;
  // Dividend / quotient width and restoring steps per element.
  localparam int DW    = 2 * N_DEF;
  localparam int STEPS = 2 * N_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Quotient reported for a zero divisor; truncated to the quotient width at use.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage
`default_nettype wire

// File: rtl/elementwise_division_if.sv
`default_nettype none
// ============================================================================
//  Module   : elementwise_division_if
//  Brief    : Operand/result handshake bundle for the element-wise divider
//  Revision : 1.0 - initial release
// ============================================================================
interface elementwise_division_if
  import elementwise_division_pkg::*;
#(
  parameter int N = N_DEF
);

  logic                     in_valid;
  logic                     in_ready;
  logic [0:N-1][2*N-1:0]    dividend;
  logic [0:N-1][N-1:0]      divisor;
  logic                     out_valid;
  logic                     out_ready;
  logic [0:N-1][2*N-1:0]    quotient;
  logic [0:N-1][N-1:0]      remainder;
  logic [N-1:0]             div_by_zero;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // The divider itself.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/elementwise_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : elementwise_div_step
//  Brief    : One combinational restoring-division step
//  Revision : 1.0 - initial release
// ============================================================================
module elementwise_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_in,    // partial remainder, always < divisor
  input  logic         dvd_bit,   // next dividend bit, MSB first
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] w_shifted;
  logic [W:0] w_trial;
  logic       w_fits;

  // Shift in the dividend bit, trial-subtract, restore when negative. The kept
  // value is always below the divisor, so dropping the top bit loses nothing.
  always_comb begin
    w_shifted = {rem_in, dvd_bit};
    w_trial   = w_shifted - {1'b0, divisor};
    w_fits    = (w_shifted >= {1'b0, divisor});
    q_bit     = w_fits;
    rem_out   = W'(w_fits ? w_trial : w_shifted);
  end

endmodule
`default_nettype wire

// File: rtl/elementwise_division.sv
`default_nettype none
// ============================================================================
//  Module   : elementwise_division
//  Brief    : Sequential element-wise unsigned divider; one shared restoring
//             datapath walks the elements, 2N cycles each
//  Revision : 1.0 - initial release
// ============================================================================
module elementwise_division
  import elementwise_division_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  elementwise_division_if.slave bus
);

  localparam int QW = 2 * N;
  localparam int EW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(QW);
  localparam logic [EW-1:0] LAST_ELEM = EW'(N - 1);
  localparam logic [BW-1:0] LAST_STEP = BW'(QW - 1);

  state_e                 state_q, state_d;
  logic [EW-1:0]          elem_idx_q, elem_idx_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [0:N-1][QW-1:0]   dvd_q, dvd_d;
  logic [0:N-1][N-1:0]    dvs_q, dvs_d;
  logic [N-1:0]           prem_q, prem_d;
  logic [QW-2:0]          qacc_q, qacc_d;
  logic [0:N-1][QW-1:0]   quot_q, quot_d;
  logic [0:N-1][N-1:0]    rem_q, rem_d;
  logic [N-1:0]           dbz_q, dbz_d;

  logic [QW-1:0]          w_cur_dvd;
  logic [N-1:0]           w_cur_dvs;
  logic                   w_dvd_bit;
  logic [N-1:0]           w_prem_next;
  logic                   w_q_bit;
  logic                   w_zero;

  // Select the operands of the element being worked on (captured copies only).
  always_comb begin
    w_cur_dvd = dvd_q[elem_idx_q];
    w_cur_dvs = dvs_q[elem_idx_q];
    w_dvd_bit = w_cur_dvd[LAST_STEP - bit_cnt_q];
    w_zero    = (w_cur_dvs == '0);
  end

  elementwise_div_step #(
    .W (N)
  ) u_step (
    .rem_in  (prem_q),
    .dvd_bit (w_dvd_bit),
    .divisor (w_cur_dvs),
    .rem_out (w_prem_next),
    .q_bit   (w_q_bit)
  );

  // Next-state logic: capture in IDLE, step in DIV, hold results in DONE.
  always_comb begin
    state_d    = state_q;
    elem_idx_d = elem_idx_q;
    bit_cnt_d  = bit_cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    qacc_d     = qacc_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d      = bus.dividend;
          dvs_d      = bus.divisor;
          elem_idx_d = '0;
          bit_cnt_d  = '0;
          prem_d     = '0;
          qacc_d     = '0;
          state_d    = DIV;
        end
      end
      DIV: begin
        prem_d = w_prem_next;
        qacc_d = {qacc_q[QW-3:0], w_q_bit};
        if (bit_cnt_q == LAST_STEP) begin
          // A zero divisor still takes the full step count for fixed latency.
          quot_d[elem_idx_q] = w_zero ? QW'(DIV0_QUOTIENT) : {qacc_q, w_q_bit};
          rem_d[elem_idx_q]  = w_zero ? w_cur_dvd[N-1:0] : w_prem_next;
          dbz_d[elem_idx_q]  = w_zero;
          prem_d     = '0;
          qacc_d     = '0;
          bit_cnt_d  = '0;
          elem_idx_d = elem_idx_q + 1'b1;
          if (elem_idx_q == LAST_ELEM) begin
            state_d = DONE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      elem_idx_q <= '0;
      bit_cnt_q  <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      qacc_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= '0;
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      prem_q     <= prem_d;
      qacc_q     <= qacc_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_elementwise_division.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elementwise_division
//  Brief    : Self-checking bench for elementwise_division
//  Revision : 1.0 - initial release
// ============================================================================
module tb_elementwise_division;

  localparam int N  = 8;
  localparam int QW = 2 * N;
  localparam int LATENCY = 2 * N * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elementwise_division_if #(.N(N)) bus ();

  elementwise_division #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [0:N-1][QW-1:0] s_dvd;
  logic [0:N-1][N-1:0]  s_dvs;
  logic [0:N-1][QW-1:0] exp_q;
  logic [0:N-1][N-1:0]  exp_r;
  logic [N-1:0]         exp_z;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned division, with the zero-divisor convention.
  task automatic build_expected();
    for (int i = 0; i < N; i++) begin
      if (s_dvs[i] == '0) begin
        exp_q[i] = '1;
        exp_r[i] = s_dvd[i][N-1:0];
        exp_z[i] = 1'b1;
      end else begin
        exp_q[i] = s_dvd[i] / {8'b0, s_dvs[i]};
        exp_r[i] = N'(s_dvd[i] % {8'b0, s_dvs[i]});
        exp_z[i] = 1'b0;
      end
    end
  endtask

  task automatic random_vector(input bit allow_zero);
    for (int i = 0; i < N; i++) begin
      s_dvd[i] = QW'($urandom);
      s_dvs[i] = N'($urandom_range(1, 255));
      if (allow_zero && $urandom_range(0, 7) == 0) s_dvs[i] = '0;
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      bus.dividend[i] = QW'($urandom);
      bus.divisor[i]  = N'($urandom);
    end
  endtask

  // Present s_dvd/s_dvs and let the DUT accept them on the next edge.
  task automatic start_op();
    build_expected();
    @(negedge clk);
    bus.dividend = s_dvd;
    bus.divisor  = s_dvs;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("accept_in_ready_low", {127'b0, bus.in_ready}, 128'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_done();
    int lat = 0;
    while (!bus.out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 128'(lat), 128'(LATENCY));
  endtask

  task automatic check_results(input string tag);
    check({tag, "_quotient"},  bus.quotient,    exp_q);
    check({tag, "_remainder"}, bus.remainder,   exp_r);
    check({tag, "_dbz"},       bus.div_by_zero, exp_z);
    check({tag, "_in_ready"},  {127'b0, bus.in_ready}, 128'd0);
  endtask

  task automatic finish_hs();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_out_valid_low", {127'b0, bus.out_valid}, 128'd0);
    check("hs_in_ready_high", {127'b0, bus.in_ready}, 128'd1);
    check("hs_retained",      bus.quotient, exp_q);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_normal(input string tag);
    start_op();
    wait_done();
    check_results(tag);
    finish_hs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {127'b0, bus.in_ready},  128'd1);
    check("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
    check("rst_quotient",  bus.quotient,  128'd0);
    check("rst_remainder", bus.remainder, 128'd0);
    check("rst_dbz",       bus.div_by_zero, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiplier round trip.
    for (int i = 0; i < N; i++) begin
      s_dvd[i] = QW'((i + 1) * 3);
      s_dvs[i] = 8'd3;
    end
    run_normal("roundtrip");

    // Extremes in the first three lanes.
    random_vector(1'b0);
    s_dvd[0] = 16'hFFFF; s_dvs[0] = 8'h01;
    s_dvd[1] = 16'hFFFF; s_dvs[1] = 8'hFF;
    s_dvd[2] = 16'd5;    s_dvs[2] = 8'd7;
    run_normal("extremes");

    // Divide by zero in lane 3.
    random_vector(1'b0);
    s_dvd[3] = 16'h1234; s_dvs[3] = 8'h00;
    run_normal("div0");

    // Backpressure in DONE with the inputs churning.
    random_vector(1'b1);
    start_op();
    wait_done();
    check_results("bp");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      scramble_inputs();
      @(posedge clk);
      #1;
      check("bp_out_valid", {127'b0, bus.out_valid}, 128'd1);
      check("bp_in_ready",  {127'b0, bus.in_ready},  128'd0);
      check("bp_stable_q",  bus.quotient,  exp_q);
      check("bp_stable_r",  bus.remainder, exp_r);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    finish_hs();

    // Reset in the middle of DIV.
    random_vector(1'b1);
    start_op();
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {127'b0, bus.in_ready},  128'd1);
    check("mid_rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
    check("mid_rst_quotient",  bus.quotient,  128'd0);
    check("mid_rst_remainder", bus.remainder, 128'd0);
    check("mid_rst_dbz",       bus.div_by_zero, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    random_vector(1'b1);
    run_normal("post_rst");

    // Back-to-back: in_valid and out_ready both held high.
    random_vector(1'b1);
    build_expected();
    @(negedge clk);
    bus.dividend  = s_dvd;
    bus.divisor   = s_dvs;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_accept_a", {127'b0, bus.in_ready}, 128'd0);
    @(negedge clk);
    random_vector(1'b1);
    bus.dividend = s_dvd;
    bus.divisor  = s_dvs;
    wait_done();
    check_results("b2b_a");
    @(posedge clk);
    #1;
    check("b2b_idle", {127'b0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    check("b2b_accept_b", {127'b0, bus.in_ready}, 128'd0);
    build_expected();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    wait_done();
    check_results("b2b_b");
    finish_hs();

    // A few fully random vectors, zero divisors included.
    for (int v = 0; v < 4; v++) begin
      random_vector(1'b1);
      run_normal("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/elementwise_division.md
Name: elementwise_division

Overview:
Sequential element-wise divider; the inverse of the element-wise multiplier. It takes N dividends of 2N bits (for example, a product vector) and N divisors of N bits. It returns, per element, a 2N-bit quotient, an N-bit remainder and a divide-by-zero flag. A single shared restoring-division datapath is time-multiplexed across the elements, with valid/ready handshakes on input and output. It sits downstream of the multiplier in the vector-arithmetic path, for example to recover a[i] from result[i] and b[i].

Parameters:
N, 8, element count; also the divisor width. Dividend and quotient width is 2N.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous and active-low
in_valid  input  1  operand vector valid
in_ready  output  1  block idle and able to accept operands
dividend  input  [2N-1:0] x [0:N-1]  dividend array
divisor  input  [N-1:0] x [0:N-1]  divisor array
out_valid  output  1  result vector valid
out_ready  input  1  consumer accepts result
quotient  output  [2N-1:0] x [0:N-1]  quotient array
remainder  output  [N-1:0] x [0:N-1]  remainder array
div_by_zero  output  [N-1:0]  bit i set when divisor[i] was 0

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE.
  - quotient, remainder and div_by_zero are cleared to 0.
  - out_valid = 0 and in_ready = 1.
  - Any operation in flight is discarded.
- State machine: IDLE -> DIV -> DONE -> IDLE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - When in_valid && in_ready: capture all dividends and divisors into internal registers, clear elem_idx and bit_cnt, go to DIV.
- DIV:
  - in_ready = 0, out_valid = 0.
  - One restoring-division step per cycle on element elem_idx:
    - Partial remainder is N+1 bits: shift in the dividend MSB-first, trial-subtract the divisor.
    - If the difference is non-negative, keep it and the quotient bit is 1; otherwise restore and the quotient bit is 0.
  - 2N steps per element. After step 2N-1, write the quotient and remainder into output register elem_idx, then increment elem_idx and clear bit_cnt.
  - After element N-1 completes, go to DONE.
  - Zero divisor:
    - Timing is unchanged: the full 2N cycles are still consumed, giving fixed latency.
    - Result is forced to quotient = all ones, remainder = dividend[i][N-1:0], div_by_zero[i] = 1.
  - The divide-by-zero check uses the captured divisor, not the live input.
- Latency: operands accepted on edge t; out_valid rises after edge t + 2N*N; N=8 gives 128 cycles in DIV.
- DONE:
  - out_valid = 1; all result outputs are held stable until out_ready is sampled high.
  - On out_valid && out_ready, go to IDLE; out_valid falls and in_ready rises on the next cycle.
  - Result registers retain their values after the handshake until overwritten by the next operation.
- There is no overlap of operations. in_valid is ignored while not in IDLE; input ports may change freely after capture.
- Width rules:
  - quotient = floor(dividend / divisor), which is 2N bits and never overflows for a nonzero divisor.
  - remainder < divisor.
  - Everything is unsigned.
- Simultaneous events: rst_n assertion overrides any handshake in the same cycle.

Decomposition:
- Shared package holds:
  - the localparams DW = 2N and STEPS = 2N;
  - the state encoding enum (IDLE, DIV, DONE);
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module: elementwise_div_step, a combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
- Counters, operand registers and the FSM stay in the top module.

Test Plan:
1. Multiplier round-trip, N=8: dividend[i] = (i+1)*3, divisor[i] = 3 -> quotient[i] = i+1, remainder 0, div_by_zero = 0; out_valid exactly 128 cycles after the accept edge.
2. Extremes: dividend 16'hFFFF with divisor 8'h01 -> quotient 16'hFFFF, remainder 0; dividend 16'hFFFF with divisor 8'hFF -> quotient 16'h0101, remainder 0; dividend 5 with divisor 7 -> quotient 0, remainder 5.
3. Divide by zero: element 3 gets dividend 16'h1234, divisor 0; other elements are normal -> quotient[3] = 16'hFFFF, remainder[3] = 8'h34, div_by_zero = 8'b0000_1000; other elements correct; latency still 128 cycles.
4. Backpressure: hold out_ready low for 10 cycles in DONE while toggling in_valid and the inputs -> out_valid stays 1, outputs stable, in_ready stays 0; release -> in_ready = 1 on the next cycle.
5. Mid-operation reset: assert rst_n low at cycle 50 of DIV -> all outputs zero, in_ready = 1 immediately; after release, a new vector produces correct results with full latency.
6. Back-to-back: in_valid held high with out_ready tied to 1 -> second vector accepted one cycle after the first handshake; both result sets are correct.
